// File: rtl/count_pwm_pkg.sv
// Shared types, constants and the duty clamp for the count_pwm block.
package count_pwm_pkg;

  localparam int CNT_WIDTH = 4;

  typedef logic [CNT_WIDTH:0] duty_t;

  localparam duty_t DUTY_MAX = duty_t'(1 << CNT_WIDTH);

  // Saturate a requested duty to 2^w (a full-period high output).
  function automatic logic [31:0] clamp_duty(input logic [31:0] duty, input int w);
    logic [31:0] max_v;
    max_v = 32'd1 << w;
    return (duty > max_v) ? max_v : duty;
  endfunction

endpackage

// File: rtl/count_wrap_det.sv
// Tracks the previous counter sample and flags period wrap; with
// COUNT_PWM_SEQCHK_EN also reports an illegal step in the count sequence.
module count_wrap_det #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             wrap
`ifdef COUNT_PWM_SEQCHK_EN
  ,
  output logic             seq_bad
`endif
);

  logic [WIDTH-1:0] prev_cnt;
  logic             prev_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cnt <= '0;
      prev_vld <= 1'b0;
    end else begin
      prev_cnt <= cnt_i;
      prev_vld <= 1'b1;
    end
  end

  // A hold at the top count is not a wrap; only the 2^WIDTH-1 -> 0 step is.
  assign wrap = prev_vld & (prev_cnt == {WIDTH{1'b1}}) & (cnt_i == '0);

`ifdef COUNT_PWM_SEQCHK_EN
  logic [WIDTH-1:0] prev_inc;
  assign prev_inc = prev_cnt + 1'b1;
  assign seq_bad  = prev_vld & (cnt_i != prev_cnt) & (cnt_i != prev_inc);
`endif

endmodule

// File: rtl/count_pwm.sv
// PWM generator driven by an external up-counter, with a double-buffered duty.
// Optional count-sequence checking is enabled by COUNT_PWM_SEQCHK_EN.
module count_pwm
  import count_pwm_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH:0]   duty_i,
  input  logic             duty_valid_i,
  output logic             duty_ready_o,
  output logic             pwm_o,
  output logic             period_o,
  output logic             seq_err_o
);

  logic           wrap;
  logic           accept;
  logic           apply;
  logic           sh_full;
  logic [WIDTH:0] duty_sh;
  logic [WIDTH:0] duty_act;
  logic [WIDTH:0] duty_nxt;
  logic [WIDTH:0] duty_clamped;

`ifdef COUNT_PWM_SEQCHK_EN
  logic seq_bad;
  logic seq_err_q;
`endif

  count_wrap_det #(.WIDTH(WIDTH)) u_wrap_det (
    .clk   (clk),
    .rst   (rst),
    .cnt_i (cnt_i),
    .wrap  (wrap)
`ifdef COUNT_PWM_SEQCHK_EN
    ,
    .seq_bad (seq_bad)
`endif
  );

  // Duty handshake: a transfer happens on any clk edge where duty_valid_i and
  // duty_ready_o are both high; the source holds duty_i stable until then.
  // Ready is low while the shadow holds a value not yet applied at a wrap.
  assign duty_ready_o = ~sh_full & ~rst;
  assign accept       = duty_valid_i & duty_ready_o;
  assign apply        = wrap & sh_full;
  assign duty_nxt     = apply ? duty_sh : duty_act;
  assign duty_clamped = (WIDTH+1)'(clamp_duty(32'(duty_i), WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh  <= '0;
      duty_act <= '0;
      sh_full  <= 1'b0;
      pwm_o    <= 1'b0;
      period_o <= 1'b0;
    end else begin
      if (apply) begin
        duty_act <= duty_sh;
      end
      // accept needs an empty shadow, so it never collides with apply.
      if (accept) begin
        duty_sh <= duty_clamped;
        sh_full <= 1'b1;
      end else if (apply) begin
        sh_full <= 1'b0;
      end
      pwm_o    <= ({1'b0, cnt_i} < duty_nxt);
      period_o <= wrap;
    end
  end

`ifdef COUNT_PWM_SEQCHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err_q <= 1'b0;
    end else if (seq_bad) begin
      seq_err_q <= 1'b1;
    end
  end
  assign seq_err_o = seq_err_q;
`else
  assign seq_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_count_pwm.sv
// Directed bench for count_pwm: reset, duty loads, clamping, back-pressure,
// sequence checking and reset with a pending shadow value.
module tb_count_pwm;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] cnt_i;
  logic [WIDTH:0]   duty_i;
  logic             duty_valid_i;
  logic             duty_ready_o;
  logic             pwm_o;
  logic             period_o;
  logic             seq_err_o;

  int checks   = 0;
  int failures = 0;

  count_pwm #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .cnt_i        (cnt_i),
    .duty_i       (duty_i),
    .duty_valid_i (duty_valid_i),
    .duty_ready_o (duty_ready_o),
    .pwm_o        (pwm_o),
    .period_o     (period_o),
    .seq_err_o    (seq_err_o)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Present a count, take one edge, then settle so outputs can be sampled.
  task automatic tick(input int c);
    cnt_i = c[WIDTH-1:0];
    @(posedge clk);
    #1;
  endtask

  // One full 0..15 period expecting pwm = (c < duty_exp). Optionally loads
  // load_val at count load_at; first marks the first post-reset period.
  task automatic run_period(input int duty_exp, input int load_at, input int load_val,
                            input bit first);
    for (int c = 0; c < 16; c++) begin
      if (c == load_at) begin
        duty_i       = load_val[WIDTH:0];
        duty_valid_i = 1'b1;
      end
      tick(c);
      if (c == load_at) begin
        duty_valid_i = 1'b0;
        check("ready_after_load", 32'(duty_ready_o), 32'd0);
      end
      check($sformatf("pwm_d%0d_c%0d", duty_exp, c), 32'(pwm_o), 32'(c < duty_exp));
      check($sformatf("period_c%0d", c), 32'(period_o), 32'((c == 0) && !first));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    duty_valid_i = 1'b0;
    duty_i = '0;
    tick(0);
    check("ready_in_reset", 32'(duty_ready_o), 32'd0);
    tick(0);
    check("pwm_reset", 32'(pwm_o), 32'd0);
    check("period_reset", 32'(period_o), 32'd0);
    check("seq_err_reset", 32'(seq_err_o), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(duty_ready_o), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    cnt_i = '0;
    duty_i = '0;
    duty_valid_i = 1'b0;
    do_reset();

    // Duty 0 first period, then loads of 5, 16, 20 (clamped), 0.
    run_period(0, -1, 0, 1'b1);
    run_period(0, 8, 5, 1'b0);
    run_period(5, 8, 16, 1'b0);
    run_period(16, 8, 20, 1'b0);
    run_period(16, 8, 0, 1'b0);
    run_period(0, -1, 0, 1'b0);

    // Second load presented while the shadow is full.
    for (int c = 0; c < 16; c++) begin
      if (c == 2) begin
        duty_i = 5'd7;
        duty_valid_i = 1'b1;
      end
      tick(c);
      if (c == 2) duty_valid_i = 1'b0;
      if (c == 5) begin
        duty_i = 5'd11;
        duty_valid_i = 1'b1;
      end
      if (c >= 2) check($sformatf("ready_full_c%0d", c), 32'(duty_ready_o), 32'd0);
      check($sformatf("pwm_hold_c%0d", c), 32'(pwm_o), 32'd0);
    end
    for (int c = 0; c < 16; c++) begin
      tick(c);
      if (c == 0) check("ready_after_drain", 32'(duty_ready_o), 32'd1);
      if (c == 1) begin
        duty_valid_i = 1'b0;
        check("ready_second_accept", 32'(duty_ready_o), 32'd0);
      end
      check($sformatf("pwm_d7_c%0d", c), 32'(pwm_o), 32'(c < 7));
      check($sformatf("period7_c%0d", c), 32'(period_o), 32'(c == 0));
    end
    run_period(11, -1, 0, 1'b0);

    // Sequence checking: 15->0, holds and single steps are legal; 5->9 is not.
    tick(0);
    check("seq_wrap_ok", 32'(seq_err_o), 32'd0);
    for (int c = 1; c <= 4; c++) tick(c);
    tick(4);
    tick(5);
    check("seq_hold_ok", 32'(seq_err_o), 32'd0);
    tick(9);
`ifdef COUNT_PWM_SEQCHK_EN
    check("seq_jump_err", 32'(seq_err_o), 32'd1);
    tick(10);
    tick(11);
    check("seq_err_sticky", 32'(seq_err_o), 32'd1);
`else
    check("seq_jump_off", 32'(seq_err_o), 32'd0);
`endif
    do_reset();

    // Pending shadow 9 with active duty 3, then reset mid-period.
    run_period(0, 8, 3, 1'b1);
    for (int c = 0; c < 10; c++) begin
      if (c == 8) begin
        duty_i = 5'd9;
        duty_valid_i = 1'b1;
      end
      tick(c);
      if (c == 8) duty_valid_i = 1'b0;
      check($sformatf("pwm_d3_c%0d", c), 32'(pwm_o), 32'(c < 3));
    end
    rst = 1'b1;
    tick(10);
    check("ready_mid_reset", 32'(duty_ready_o), 32'd0);
    check("pwm_mid_reset", 32'(pwm_o), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_post_mid_reset", 32'(duty_ready_o), 32'd1);
    for (int c = 11; c < 16; c++) begin
      tick(c);
      check($sformatf("pwm_post_rst_c%0d", c), 32'(pwm_o), 32'd0);
      check($sformatf("period_post_rst_c%0d", c), 32'(period_o), 32'd0);
    end
    run_period(0, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
